// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson code to phase index/one-hot decoder with lock tracking
// Optional revolution counter built only when JDEC_REV_COUNT_EN is defined.
module johnson_phase_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_STEPS = 3,
    parameter int REV_W      = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [WIDTH-1:0]            i_count,
    input  logic                        i_err_clr,
    output logic [$clog2(2*WIDTH)-1:0]  o_phase_idx,
    output logic [2*WIDTH-1:0]          o_phase_onehot,
    output logic                        o_code_valid,
    output logic                        o_locked,
    output logic                        o_step_err,
    output logic                        o_err_sticky,
    output logic [REV_W-1:0]            o_rev_count,
    output logic                        o_rev_tick
);

    localparam int N  = 2 * WIDTH;
    localparam int IW = $clog2(N);

    typedef enum logic {S_UNLOCK, S_LOCK} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [N-1:0]    r_onehot;
    logic            r_code_valid;
    logic            r_prev_valid;
    logic [3:0]      r_good_cnt;
    logic [3:0]      w_good_nxt;
    logic [3:0]      w_good_inc;
    logic            r_step_err;
    logic            r_err_sticky;

    logic            w_legal;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_idx_inc;
    logic            w_step_ok;
    logic            w_good;
    logic            w_err;
    logic [N-1:0]    w_onehot;

    // Legal codes are a run of low ones (MSB=0) or a run of low zeros (MSB=1).
    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (i_count == WIDTH'((1 << k) - 1)) begin
                w_legal = 1'b1;
                w_idx   = IW'(k);
            end else if (i_count == ~WIDTH'((1 << k) - 1)) begin
                w_legal = 1'b1;
                w_idx   = IW'(WIDTH + k);
            end
        end
    end

    assign w_idx_inc = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
    assign w_step_ok = !r_prev_valid || (w_idx == r_idx) || (w_idx == w_idx_inc);
    assign w_good    = w_legal && w_step_ok;
    assign w_err     = (r_state == S_LOCK) && !w_good;
    assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_idx;
    assign w_good_inc = r_good_cnt + 4'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_UNLOCK;
            r_idx        <= '0;
            r_onehot     <= '0;
            r_code_valid <= 1'b0;
            r_prev_valid <= 1'b0;
            r_good_cnt   <= 4'd0;
            r_step_err   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good_cnt   <= w_good_nxt;
            r_code_valid <= w_legal;
            r_prev_valid <= w_legal;
            r_onehot     <= w_legal ? w_onehot : '0;
            if (w_legal) begin
                r_idx <= w_idx;
            end
            r_step_err   <= w_err;
            r_err_sticky <= w_err | (r_err_sticky & ~i_err_clr);
        end
    end

    // A legal sample that breaks lock becomes the first good sample of the relock run.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        if (r_state == S_UNLOCK) begin
            if (w_good) begin
                w_good_nxt = w_good_inc;
                if (w_good_inc >= 4'(LOCK_STEPS)) begin
                    w_state_nxt = S_LOCK;
                end
            end else begin
                w_good_nxt = 4'd0;
            end
        end else if (!w_good) begin
            w_state_nxt = S_UNLOCK;
            w_good_nxt  = w_legal ? 4'd1 : 4'd0;
        end
    end

    always_comb begin
        o_phase_idx    = r_idx;
        o_phase_onehot = r_onehot;
        o_code_valid   = r_code_valid;
        o_locked       = (r_state == S_LOCK);
        o_step_err     = r_step_err;
        o_err_sticky   = r_err_sticky;
    end

`ifdef JDEC_REV_COUNT_EN
    logic [REV_W-1:0] r_rev_count;
    logic             r_rev_tick;
    logic             w_wrap;

    assign w_wrap = (r_state == S_LOCK) && w_legal && r_prev_valid &&
                    (r_idx == IW'(N - 1)) && (w_idx == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rev_count <= '0;
            r_rev_tick  <= 1'b0;
        end else begin
            r_rev_tick <= w_wrap;
            if (w_wrap) begin
                r_rev_count <= r_rev_count + 1'b1;
            end
        end
    end

    assign o_rev_count = r_rev_count;
    assign o_rev_tick  = r_rev_tick;
`else
    assign o_rev_count = '0;
    assign o_rev_tick  = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - table-driven scoreboard bench for johnson_phase_decoder
module tb_johnson_phase_decoder;

`ifdef JDEC_REV_COUNT_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] oh;
        logic       v;
        logic       l;
        logic       se;
        logic       st;
        logic [7:0] rev;
        logic       tick;
    } out_t;

    typedef struct {
        logic       rst;
        logic [3:0] cnt;
        logic       clr;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt = 4'b0000;
    logic       clr = 1'b0;
    logic [2:0] phase_idx;
    logic [7:0] phase_onehot;
    logic       code_valid, locked, step_err, err_sticky, rev_tick;
    logic [7:0] rev_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    out_t sb_q[$];
    vec_t vecs[$];
    logic [3:0] codes [8];

    johnson_phase_decoder #(.WIDTH(4), .LOCK_STEPS(3), .REV_W(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_count        (cnt),
        .i_err_clr      (clr),
        .o_phase_idx    (phase_idx),
        .o_phase_onehot (phase_onehot),
        .o_code_valid   (code_valid),
        .o_locked       (locked),
        .o_step_err     (step_err),
        .o_err_sticky   (err_sticky),
        .o_rev_count    (rev_count),
        .o_rev_tick     (rev_tick)
    );

    always #5 clk = ~clk;

    function automatic out_t mko(int idx, int oh, bit v, bit l, bit se, bit st, int rev, bit tick);
        out_t o;
        o.idx  = 3'(idx);
        o.oh   = 8'(oh);
        o.v    = v;
        o.l    = l;
        o.se   = se;
        o.st   = st;
        o.rev  = REV_EN ? 8'(rev) : 8'd0;
        o.tick = REV_EN ? tick : 1'b0;
        return o;
    endfunction

    function automatic vec_t mk(bit r, logic [3:0] c, bit k, out_t e);
        vec_t x;
        x.rst = r;
        x.cnt = c;
        x.clr = k;
        x.exp = e;
        return x;
    endfunction

    task automatic drive(input bit r, input logic [3:0] c, input bit k, input out_t e, input string name);
        out_t exp;
        out_t act;
        rst = r;
        cnt = c;
        clr = k;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        act = {phase_idx, phase_onehot, code_valid, locked, step_err, err_sticky, rev_count, rev_tick};
        exp = sb_q.pop_front();
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got idx=%0d oh=%h valid=%b lock=%b serr=%b sticky=%b rev=%0d tick=%b; expected idx=%0d oh=%h valid=%b lock=%b serr=%b sticky=%b rev=%0d tick=%b",
                     name, act.idx, act.oh, act.v, act.l, act.se, act.st, act.rev, act.tick,
                     exp.idx, exp.oh, exp.v, exp.l, exp.se, exp.st, exp.rev, exp.tick);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b0111;
        codes[4] = 4'b1111; codes[5] = 4'b1110; codes[6] = 4'b1100; codes[7] = 4'b1000;

        // reset, then lock on a held 0000
        vecs.push_back(mk(1, 4'b0000, 0, mko(0, 8'h00, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 4'b0000, 0, mko(0, 8'h00, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b0000, 0, mko(0, 8'h01, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b0000, 0, mko(0, 8'h01, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b0000, 0, mko(0, 8'h01, 1, 1, 0, 0, 0, 0)));
        // full revolution
        vecs.push_back(mk(0, 4'b0001, 0, mko(1, 8'h02, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b0011, 0, mko(2, 8'h04, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b0111, 0, mko(3, 8'h08, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b1111, 0, mko(4, 8'h10, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b1110, 0, mko(5, 8'h20, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b1100, 0, mko(6, 8'h40, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b1000, 0, mko(7, 8'h80, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b0000, 0, mko(0, 8'h01, 1, 1, 0, 0, 1, 1)));
        vecs.push_back(mk(0, 4'b0000, 0, mko(0, 8'h01, 1, 1, 0, 0, 1, 0)));
        // illegal code while locked at idx 2
        vecs.push_back(mk(0, 4'b0001, 0, mko(1, 8'h02, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mk(0, 4'b0011, 0, mko(2, 8'h04, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mk(0, 4'b0101, 0, mko(2, 8'h00, 0, 0, 1, 1, 1, 0)));
        // relock and walk to idx 1
        vecs.push_back(mk(0, 4'b0011, 0, mko(2, 8'h04, 1, 0, 0, 1, 1, 0)));
        vecs.push_back(mk(0, 4'b0111, 0, mko(3, 8'h08, 1, 0, 0, 1, 1, 0)));
        vecs.push_back(mk(0, 4'b1111, 0, mko(4, 8'h10, 1, 1, 0, 1, 1, 0)));
        vecs.push_back(mk(0, 4'b1110, 0, mko(5, 8'h20, 1, 1, 0, 1, 1, 0)));
        vecs.push_back(mk(0, 4'b1100, 0, mko(6, 8'h40, 1, 1, 0, 1, 1, 0)));
        vecs.push_back(mk(0, 4'b1000, 0, mko(7, 8'h80, 1, 1, 0, 1, 1, 0)));
        vecs.push_back(mk(0, 4'b0000, 0, mko(0, 8'h01, 1, 1, 0, 1, 2, 1)));
        vecs.push_back(mk(0, 4'b0001, 0, mko(1, 8'h02, 1, 1, 0, 1, 2, 0)));
        // illegal step 1 -> 3, then relock after 1110
        vecs.push_back(mk(0, 4'b0111, 0, mko(3, 8'h08, 1, 0, 1, 1, 2, 0)));
        vecs.push_back(mk(0, 4'b1111, 0, mko(4, 8'h10, 1, 0, 0, 1, 2, 0)));
        vecs.push_back(mk(0, 4'b1110, 0, mko(5, 8'h20, 1, 1, 0, 1, 2, 0)));
        // err_clr together with a new error: error wins; then clear alone
        vecs.push_back(mk(0, 4'b0101, 1, mko(5, 8'h00, 0, 0, 1, 1, 2, 0)));
        vecs.push_back(mk(0, 4'b1110, 1, mko(5, 8'h20, 1, 0, 0, 0, 2, 0)));
        // illegal code while unlocked: no pulse, no sticky
        vecs.push_back(mk(0, 4'b0101, 0, mko(5, 8'h00, 0, 0, 0, 0, 2, 0)));
        // relock, wrap to rev 3, walk to idx 5, then reset mid-run
        vecs.push_back(mk(0, 4'b1110, 0, mko(5, 8'h20, 1, 0, 0, 0, 2, 0)));
        vecs.push_back(mk(0, 4'b1100, 0, mko(6, 8'h40, 1, 0, 0, 0, 2, 0)));
        vecs.push_back(mk(0, 4'b1000, 0, mko(7, 8'h80, 1, 1, 0, 0, 2, 0)));
        vecs.push_back(mk(0, 4'b0000, 0, mko(0, 8'h01, 1, 1, 0, 0, 3, 1)));
        vecs.push_back(mk(0, 4'b0001, 0, mko(1, 8'h02, 1, 1, 0, 0, 3, 0)));
        vecs.push_back(mk(0, 4'b0011, 0, mko(2, 8'h04, 1, 1, 0, 0, 3, 0)));
        vecs.push_back(mk(0, 4'b0111, 0, mko(3, 8'h08, 1, 1, 0, 0, 3, 0)));
        vecs.push_back(mk(0, 4'b1111, 0, mko(4, 8'h10, 1, 1, 0, 0, 3, 0)));
        vecs.push_back(mk(0, 4'b1110, 0, mko(5, 8'h20, 1, 1, 0, 0, 3, 0)));
        vecs.push_back(mk(1, 4'b1100, 1, mko(0, 8'h00, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 4'b1100, 0, mko(6, 8'h40, 1, 0, 0, 0, 0, 0)));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cnt, vecs[i].clr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // two clean revolutions from a fresh reset: ticks only on the 7 -> 0 steps
        drive(1, 4'b0000, 0, mko(0, 8'h00, 0, 0, 0, 0, 0, 0), "rev_reset");
        drive(0, 4'b0000, 0, mko(0, 8'h01, 1, 0, 0, 0, 0, 0), "rev_lock1");
        drive(0, 4'b0000, 0, mko(0, 8'h01, 1, 0, 0, 0, 0, 0), "rev_lock2");
        drive(0, 4'b0000, 0, mko(0, 8'h01, 1, 1, 0, 0, 0, 0), "rev_lock3");
        for (int s = 1; s <= 16; s++) begin
            drive(0, codes[s % 8], 0,
                  mko(s % 8, 1 << (s % 8), 1, 1, 0, 0, s / 8, (s % 8) == 0),
                  $sformatf("rev_step%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Downstream consumer of the parameterized Johnson counter. It takes the counter's `count` bus and converts the Johnson code into a phase index and a one-hot phase vector. It checks every sample for illegal codes and illegal steps, locks once it has seen enough consecutive legal steps, and can optionally count full revolutions. It sits between the Johnson counter and the multi-phase enable logic, giving downstream blocks a validated phase plus an error indication.

## Interface
- `WIDTH`, default 4: width of the Johnson code; phase count N = 2*WIDTH.
- `LOCK_STEPS`, default 3: consecutive legal samples needed to assert `locked`; range 1..15.
- `REV_W`, default 8: width of the revolution counter.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `count`  in  WIDTH: Johnson code from the upstream counter; sampled every cycle.
- `err_clr`  in  1: clears `err_sticky`.
- `phase_idx`  out  clog2(2*WIDTH): decoded phase 0..N-1.
- `phase_onehot`  out  2*WIDTH: bit `phase_idx` set while `code_valid`=1, otherwise all-zero.
- `code_valid`  out  1: last sample was a legal Johnson code.
- `locked`  out  1: decoder is in the LOCK state.
- `step_err`  out  1: one-cycle pulse on an error while locked.
- `err_sticky`  out  1: latched error flag.
- `rev_count`  out  REV_W: number of completed revolutions.
- `rev_tick`  out  1: one-cycle pulse on each revolution wrap.

## Operation
- **Legal codes:**
  - With MSB=0, the code is `2^k-1` for k=0..WIDTH-1, and idx=k (number of ones).
  - With MSB=1, the code is `~(2^k-1)` for k=0..WIDTH-1, and idx=WIDTH+k (number of zeros).
  - Any other code is illegal.
- **Legal step** (relative to the previous legal idx, when `prev_valid`=1):
  - new idx == prev idx (the counter is holding because enable is low), or
  - new idx == (prev idx+1) mod N.
- **State machine:**
  - UNLOCK, the reset state:
    - A legal code that is also a legal step (or arrives with `prev_valid`=0) increments `good_cnt`.
    - An illegal code, or a legal code with an illegal step, sets `good_cnt`=0.
    - When `good_cnt` reaches `LOCK_STEPS`, go to LOCK.
  - LOCK:
    - An illegal code or illegal step: pulse `step_err`, set `err_sticky`, go to UNLOCK, set `good_cnt`=0.
    - A legal code with an illegal step also sets `good_cnt`=1, so that sample is the new reference.
- **Outputs on an illegal code:**
  - `code_valid`=0, `phase_onehot`=0.
  - `phase_idx` and the reference idx hold their last legal value.
  - `prev_valid` is cleared.
- **Errors in UNLOCK:** do not pulse `step_err` and do not set `err_sticky`.
- **Revolution:** in LOCK, a step from idx N-1 to 0 pulses `rev_tick` and increments `rev_count` modulo 2^REV_W. The counter wraps from all-ones to 0 without any flag.
- **err_clr:**
  - Clears `err_sticky` on the next edge.
  - If a new error is detected in the same cycle, the error wins and `err_sticky` stays 1.

## Timing
- Single register stage: a `count` sampled at edge t is reflected in every output after edge t, giving 1-cycle latency.
- Reset values: `phase_idx`=0, `phase_onehot`=0, `code_valid`=0, `locked`=0, `step_err`=0, `err_sticky`=0, `rev_count`=0, `rev_tick`=0; internally `good_cnt`=0 and `prev_valid`=0.
- Asserting `rst` mid-operation forces all of the above at the next edge. `rst` has priority over every other input.
- `locked` rises on the edge that registers the `LOCK_STEPS`-th consecutive legal sample.
- `step_err` and `locked` falling happen on the same edge.
- `rev_tick` is high for exactly one cycle per wrap, and `rev_count` updates on that same edge.
- A held code in LOCK is legal and produces no `rev_tick`.

## Configuration
- `JDEC_REV_COUNT_EN`:
  - Defined: the revolution counter and `rev_tick` logic are present as described.
  - Undefined: `rev_count` is tied to 0 and `rev_tick` to 0, no revolution registers are built, and all other behaviour is unchanged.

## Test plan
All scenarios use WIDTH=4 and LOCK_STEPS=3.
- **Lock from reset:** `rst` for 2 cycles, then `count`=0000 held -> after the first edge `code_valid`=1, `phase_idx`=0, `phase_onehot`=0x01; `locked`=1 after the 3rd edge.
- **Full revolution:** locked, drive 0000,0001,0011,0111,1111,1110,1100,1000,0000 one per cycle -> `phase_idx` 0..7,0; `phase_onehot` 0x01..0x80,0x01; `rev_tick` high for one cycle on the 1000->0000 edge; `rev_count`=1; `step_err` never asserted.
- **Illegal code:** locked at 0011 (idx 2), drive 0101 -> `code_valid`=0, `phase_onehot`=0, `phase_idx`=2, `step_err` pulse, `err_sticky`=1, `locked`=0.
- **Illegal step and relock:** locked at 0001 (idx 1), drive 0111 (idx 3) -> `step_err` pulse, `locked`=0, `phase_idx`=3; then drive 1111,1110 -> `locked`=1 after the 1110 edge.
- **err_clr priority:** assert `err_clr` in the same cycle as an illegal code -> `err_sticky` stays 1; `err_clr` alone next cycle -> `err_sticky`=0.
- **Reset mid-run and macro-off build:** `rst` mid-run at idx 5 with `rev_count`=3 -> all outputs return to reset values next edge. Build without `JDEC_REV_COUNT_EN` and rerun the full-revolution scenario -> `rev_count`=0 and `rev_tick`=0 throughout.
